// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and default operand width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor (a - b - bin); purely combinational, zero latency, no flow control.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock; valid appears WIDTH cycles after the start edge.
// Result is held with valid until ack; start is ignored while busy, so jobs never queue.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             valid,
  input  logic             ack
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, diff_r;
  logic             borrow_r;
  logic [CW-1:0]    cnt;
  logic             load, step;
  logic             bit_d, bit_bout;

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow_r),
    .d    (bit_d),
    .bout (bit_bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        // ack wins over a simultaneous start; the next job needs a fresh start in IDLE
        if (ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      diff_r   <= '0;
      borrow_r <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      a_sh     <= a_in;
      b_sh     <= b_in;
      diff_r   <= '0;
      borrow_r <= 1'b0;
      cnt      <= '0;
    end else if (step) begin
      a_sh     <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh     <= {1'b0, b_sh[WIDTH-1:1]};
      diff_r   <= {bit_d, diff_r[WIDTH-1:1]};
      borrow_r <= bit_bout;
      cnt      <= cnt + 1'b1;
    end
  end

  assign busy       = (state != IDLE);
  assign valid      = (state == DONE);
  assign diff_out   = diff_r;
  assign borrow_out = borrow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor plus an exhaustive check of the full_subtractor cell.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a_in, b_in;
  logic       busy;
  logic [7:0] diff_out;
  logic       borrow_out;
  logic       valid;
  logic       ack;

  logic fs_a, fs_b, fs_bin, fs_d, fs_bout;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] diff;
    logic       borrow;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .diff_out   (diff_out),
    .borrow_out (borrow_out),
    .valid      (valid),
    .ack        (ack)
  );

  full_subtractor u_fs_ut (
    .a    (fs_a),
    .b    (fs_b),
    .bin  (fs_bin),
    .d    (fs_d),
    .bout (fs_bout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_job(input logic [7:0] a, input logic [7:0] b, input int hold,
                         input bit mid_start, input bit ack_start);
    exp_t       e;
    logic [7:0] held;
    int         n;
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    e.diff   = a - b;
    e.borrow = (a < b);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("valid_early", valid, 0);
    n = 0;
    while (!valid && n < 20) begin
      @(negedge clk);
      n++;
      if (mid_start && n == 2) begin
        start = 1'b1;
        a_in  = 8'hAA;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("latency", n, 8);
    e = sb.pop_front();
    chk("diff", diff_out, e.diff);
    chk("borrow", borrow_out, e.borrow);
    held = diff_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", valid, 1);
      chk("hold_diff", diff_out, held);
    end
    ack   = 1'b1;
    start = ack_start;
    @(negedge clk);
    ack   = 1'b0;
    start = 1'b0;
    chk("valid_after_ack", valid, 0);
    chk("busy_after_ack", busy, 0);
    chk("diff_retained", diff_out, e.diff);
    chk("borrow_retained", borrow_out, e.borrow);
    if (ack_start) begin
      @(negedge clk);
      chk("no_new_job", busy, 0);
    end
  endtask

  initial begin
    int r;
    rst   = 1'b1;
    start = 1'b0;
    ack   = 1'b0;
    a_in  = '0;
    b_in  = '0;

    for (int i = 0; i < 8; i++) begin
      fs_a   = i[2];
      fs_b   = i[1];
      fs_bin = i[0];
      #1;
      r = int'(fs_a) - int'(fs_b) - int'(fs_bin);
      chk("fs_d", fs_d, (r & 1) != 0);
      chk("fs_bout", fs_bout, r < 0);
    end

    #3;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_diff", diff_out, 0);
    chk("rst_borrow", borrow_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_job(8'd5,  8'd3,  0, 1'b0, 1'b0);
    run_job(8'd3,  8'd5,  0, 1'b0, 1'b0);
    run_job(8'hFF, 8'h00, 0, 1'b0, 1'b0);
    run_job(8'h00, 8'h01, 0, 1'b0, 1'b0);
    run_job(8'h10, 8'h01, 5, 1'b1, 1'b1);

    // abort mid-run with an asynchronous reset
    @(negedge clk);
    a_in  = 8'h77;
    b_in  = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_diff", diff_out, 0);
    chk("abort_borrow", borrow_out, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_abort_idle", busy, 0);

    run_job(8'd9, 8'd9, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
